// File: rtl/vram_fill_master.sv
// vram_fill_master
//   Avalon-MM write master that fills a rectangular character region of the
//   80x30 text-mode VRAM with a single 16-bit character word. Two characters
//   share one 32-bit VRAM word: the even column sits in bits [15:0] and the
//   odd column in bits [31:16]. Interior column pairs are written as full
//   words; ragged left/right edges use halfword byte enables.
//
// Ports
//   CLK              system clock
//   RESET            asynchronous, active-high reset
//   START            one-cycle command strobe, honoured only when idle
//   X0, Y0           top-left cell of the rectangle (inclusive)
//   X1, Y1           bottom-right cell of the rectangle (inclusive)
//   FILL_CHAR        character word {inverse, glyph[6:0], fg[3:0], bg[3:0]}
//   BUSY             high while a legal fill is in progress
//   DONE             one-cycle pulse after the last write is accepted
//   ERR              one-cycle pulse when a command has an illegal rectangle
//   AVM_ADDR         Avalon word address
//   AVM_WRITE        Avalon write request
//   AVM_CS           chip select, mirrors AVM_WRITE
//   AVM_BYTE_EN      Avalon byte enables
//   AVM_WRITEDATA    Avalon write data
//   AVM_WAITREQUEST  Avalon slave stall
module vram_fill_master #(
    parameter int          COLS          = 80,
    parameter int          ROWS          = 30,
    parameter int          WORDS_PER_ROW = COLS / 2,
    parameter logic [11:0] BASE_ADDR     = 12'h000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [6:0]  X0,
    input  logic [4:0]  Y0,
    input  logic [6:0]  X1,
    input  logic [4:0]  Y1,
    input  logic [15:0] FILL_CHAR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [11:0] AVM_ADDR,
    output logic        AVM_WRITE,
    output logic        AVM_CS,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic        AVM_WAITREQUEST
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [7:0]  COLS_L = 8'(COLS);
    localparam logic [5:0]  ROWS_L = 6'(ROWS);
    localparam logic [10:0] WPR_L  = 11'(WORDS_PER_ROW);

    logic [1:0]  state;
    logic [6:0]  x0_q, x1_q;
    logic [4:0]  y0_q, y1_q;
    logic [15:0] char_q;
    logic [6:0]  col;
    logic [4:0]  row;

    logic [7:0]  step;
    logic [7:0]  col_adv;
    logic        row_done;
    logic        last_beat;
    logic [6:0]  col_nxt;
    logic [4:0]  row_nxt;
    logic        illegal;

    // Row offset is formed at 11 bits; the largest legal address (1199)
    // never reaches bit 11.
    function automatic logic [11:0] beat_addr(input logic [6:0] c, input logic [4:0] r);
        logic [10:0] off;
        off = {6'b0, r} * WPR_L;
        return BASE_ADDR + {1'b0, off} + {6'b0, c[6:1]};
    endfunction

    function automatic logic pair_fits(input logic [6:0] c, input logic [6:0] xr);
        return !c[0] && (({1'b0, c} + 8'd1) <= {1'b0, xr});
    endfunction

    function automatic logic [3:0] beat_be(input logic [6:0] c, input logic [6:0] xr);
        if (c[0])
            return 4'b1100;
        else if (pair_fits(c, xr))
            return 4'b1111;
        else
            return 4'b0011;
    endfunction

    always_comb begin
        step      = pair_fits(col, x1_q) ? 8'd2 : 8'd1;
        col_adv   = {1'b0, col} + step;
        row_done  = col_adv > {1'b0, x1_q};
        last_beat = row_done && (row == y1_q);
        col_nxt   = row_done ? x0_q : col_adv[6:0];
        row_nxt   = row_done ? row + 5'd1 : row;
        illegal   = (x0_q > x1_q) || (y0_q > y1_q) ||
                    ({1'b0, x1_q} >= COLS_L) || ({1'b0, y1_q} >= ROWS_L);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            x0_q          <= '0;
            x1_q          <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            char_q        <= '0;
            col           <= '0;
            row           <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
            AVM_ADDR      <= '0;
            AVM_WRITE     <= 1'b0;
            AVM_CS        <= 1'b0;
            AVM_BYTE_EN   <= '0;
            AVM_WRITEDATA <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        x0_q   <= X0;
                        y0_q   <= Y0;
                        x1_q   <= X1;
                        y1_q   <= Y1;
                        char_q <= FILL_CHAR;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (illegal) begin
                        ERR   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        BUSY          <= 1'b1;
                        col           <= x0_q;
                        row           <= y0_q;
                        AVM_ADDR      <= beat_addr(x0_q, y0_q);
                        AVM_BYTE_EN   <= beat_be(x0_q, x1_q);
                        AVM_WRITEDATA <= {char_q, char_q};
                        AVM_WRITE     <= 1'b1;
                        AVM_CS        <= 1'b1;
                        state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // The next beat is loaded on the accepting edge so the
                    // bus sees one beat per cycle without idle gaps.
                    if (!AVM_WAITREQUEST) begin
                        if (last_beat) begin
                            AVM_WRITE <= 1'b0;
                            AVM_CS    <= 1'b0;
                            state     <= S_FIN;
                        end else begin
                            col         <= col_nxt;
                            row         <= row_nxt;
                            AVM_ADDR    <= beat_addr(col_nxt, row_nxt);
                            AVM_BYTE_EN <= beat_be(col_nxt, x1_q);
                        end
                    end
                end
                S_FIN: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fill_master.sv
`timescale 1ns/1ps
module tb_vram_fill_master;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [6:0]  X0 = '0;
    logic [4:0]  Y0 = '0;
    logic [6:0]  X1 = '0;
    logic [4:0]  Y1 = '0;
    logic [15:0] FILL_CHAR = '0;
    logic        BUSY, DONE, ERR;
    logic [11:0] AVM_ADDR;
    logic        AVM_WRITE, AVM_CS;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;
    logic        AVM_WAITREQUEST = 1'b0;

    int    errors = 0;
    int    checks = 0;
    beat_t q[$];
    int    acc_cnt = 0;
    longint first_acc_t = 0;
    longint last_acc_t = 0;

    vram_fill_master dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1), .FILL_CHAR(FILL_CHAR),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .AVM_ADDR(AVM_ADDR), .AVM_WRITE(AVM_WRITE), .AVM_CS(AVM_CS),
        .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
        .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted beat must match the head of the queue.
    always @(negedge CLK) begin
        if (!RESET && AVM_WRITE && !AVM_WAITREQUEST) begin
            beat_t e;
            chk("queue_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("beat_addr", 32'(AVM_ADDR), 32'(e.addr));
                chk("beat_be", 32'(AVM_BYTE_EN), 32'(e.be));
                chk("beat_data", AVM_WRITEDATA, e.data);
                chk("beat_cs", 32'(AVM_CS), 32'd1);
            end
            if (acc_cnt == 0) first_acc_t = $time;
            last_acc_t = $time;
            acc_cnt++;
        end
    end

    // Reference beat sequence for a legal rectangle.
    task automatic push_model(input int x0, input int y0, input int x1, input int y1,
                              input logic [15:0] ch, output int n);
        beat_t b;
        n = 0;
        for (int r = y0; r <= y1; r++) begin
            int c = x0;
            while (c <= x1) begin
                b.addr = 12'(r * 40 + c / 2);
                b.data = {ch, ch};
                if (c % 2 == 1) begin
                    b.be = 4'b1100; c += 1;
                end else if (c + 1 <= x1) begin
                    b.be = 4'b1111; c += 2;
                end else begin
                    b.be = 4'b0011; c += 1;
                end
                q.push_back(b);
                n++;
            end
        end
    endtask

    task automatic issue(input int x0, input int y0, input int x1, input int y1,
                         input logic [15:0] ch);
        acc_cnt = 0;
        @(posedge CLK); #1;
        X0 = 7'(x0); Y0 = 5'(y0); X1 = 7'(x1); Y1 = 5'(y1);
        FILL_CHAR = ch; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic finish_wait(input int n_exp, input bit gapless);
        int   cyc = 0;
        logic seen = 1'b0;
        logic pb = 1'b0;
        while (cyc < 3000) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            pb = BUSY;
            cyc++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("busy_low_with_done", 32'(BUSY), 32'd0);
            chk("busy_high_before_done", 32'(pb), 32'd1);
            chk("done_latency_ns", 32'($time - last_acc_t), 32'd20);
        end
        chk("beat_count", 32'(acc_cnt), 32'(n_exp));
        chk("queue_drained", 32'(q.size()), 32'd0);
        if (gapless)
            chk("gapless_span", 32'((last_acc_t - first_acc_t) / 10), 32'(n_exp - 1));
        @(negedge CLK);
        chk("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    task automatic illegal_cmd(input int x0, input int y0, input int x1, input int y1);
        int err_cnt = 0;
        issue(x0, y0, x1, y1, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (ERR) err_cnt++;
            chk("illegal_no_write", 32'(AVM_WRITE), 32'd0);
            chk("illegal_no_busy", 32'(BUSY), 32'd0);
        end
        chk("illegal_err_pulses", 32'(err_cnt), 32'd1);
        chk("illegal_no_beats", 32'(acc_cnt), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] stall_data;

        // Reset state
        @(negedge CLK); @(negedge CLK);
        chk("rst_write", 32'(AVM_WRITE), 32'd0);
        chk("rst_cs", 32'(AVM_CS), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_addr", 32'(AVM_ADDR), 32'd0);
        chk("rst_be", 32'(AVM_BYTE_EN), 32'd0);
        chk("rst_data", AVM_WRITEDATA, 32'd0);
        @(posedge CLK); #1 RESET = 1'b0;

        // Single odd cell: ADDR 2*40+1 = 81, upper halfword
        push_model(3, 2, 3, 2, 16'h8141, n);
        chk("single_model_count", 32'(n), 32'd1);
        issue(3, 2, 3, 2, 16'h8141);
        finish_wait(1, 1'b1);

        // Ragged row: (0,1100) (1,1111) (2,0011)
        push_model(1, 0, 4, 0, 16'h2A5C, n);
        issue(1, 0, 4, 0, 16'h2A5C);
        finish_wait(3, 1'b1);

        // Multi-row ragged rectangle with even start and odd end
        push_model(10, 3, 15, 6, 16'h7F0E, n);
        issue(10, 3, 15, 6, 16'h7F0E);
        finish_wait(n, 1'b1);

        // Full screen
        push_model(0, 0, 79, 29, 16'hC3A5, n);
        chk("full_model_count", 32'(n), 32'd1200);
        issue(0, 0, 79, 29, 16'hC3A5);
        finish_wait(1200, 1'b1);

        // Stall the second beat of the ragged row for 3 cycles
        push_model(1, 0, 4, 0, 16'h5511, n);
        issue(1, 0, 4, 0, 16'h5511);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        AVM_WAITREQUEST = 1'b1;
        stall_data = {16'h5511, 16'h5511};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("stall_addr", 32'(AVM_ADDR), 32'd1);
            chk("stall_be", 32'(AVM_BYTE_EN), 32'hF);
            chk("stall_data", AVM_WRITEDATA, stall_data);
            chk("stall_write", 32'(AVM_WRITE), 32'd1);
            @(posedge CLK); #1;
            if (i == 2) AVM_WAITREQUEST = 1'b0;
        end
        finish_wait(3, 1'b0);

        // Illegal rectangles
        illegal_cmd(0, 0, 80, 0);
        illegal_cmd(0, 5, 0, 4);

        // START while busy is ignored
        push_model(0, 5, 79, 5, 16'h0F0F, n);
        issue(0, 5, 79, 5, 16'h0F0F);
        repeat (8) @(posedge CLK);
        #1;
        X0 = 7'd0; Y0 = 5'd0; X1 = 7'd1; Y1 = 5'd0; FILL_CHAR = 16'hDEAD; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        finish_wait(40, 1'b1);
        repeat (5) @(negedge CLK);
        chk("no_extra_beats", 32'(acc_cnt), 32'd40);

        // Asynchronous reset mid-fill
        push_model(0, 0, 79, 29, 16'h1111, n);
        issue(0, 0, 79, 29, 16'h1111);
        repeat (20) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("async_rst_write", 32'(AVM_WRITE), 32'd0);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        chk("async_rst_done", 32'(DONE), 32'd0);
        q.delete();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_idle_write", 32'(AVM_WRITE), 32'd0);
        push_model(6, 29, 9, 29, 16'hABCD, n);
        issue(6, 29, 9, 29, 16'hABCD);
        finish_wait(2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_fill_master.md
Name: vram_fill_master

Overview:
Avalon-MM master that fills a rectangular character region of the 80x30 text-mode VRAM with one 16-bit character word (inverse bit, glyph code, foreground/background palette indices). It is the initiator side of the VGA text controller's Avalon slave port and targets VRAM word addresses 0x000–0x4AF. Software or a game FSM gives a rectangle and a character, pulses START, and receives DONE. The block packs adjacent columns into full-word writes and uses halfword byte enables at ragged edges.

Parameters:
COLS, 80, character columns per row (must be even)
ROWS, 30, character rows
WORDS_PER_ROW, COLS/2, 32-bit VRAM words per row (two characters per word)
BASE_ADDR, 12'h000, word address of VRAM cell (0,0)

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-high reset
START  in  1  one-cycle command strobe; sampled only in IDLE
X0  in  7  left column, inclusive
Y0  in  5  top row, inclusive
X1  in  7  right column, inclusive
Y1  in  5  bottom row, inclusive
FILL_CHAR  in  16  character word: [15] inverse, [14:8] glyph code, [7:4] FG palette select, [3:0] BG palette select
BUSY  out  1  high from the cycle after an accepted START until DONE
DONE  out  1  one-cycle pulse after the final write is accepted
ERR  out  1  one-cycle pulse when a START carries an illegal rectangle
AVM_ADDR  out  12  Avalon word address
AVM_WRITE  out  1  Avalon write request
AVM_CS  out  1  chip select; equals AVM_WRITE
AVM_BYTE_EN  out  4  byte enables
AVM_WRITEDATA  out  32  write data
AVM_WAITREQUEST  in  1  slave stall

Behaviour:
- Reset (asynchronous): state IDLE. BUSY, DONE, ERR, AVM_WRITE, AVM_CS = 0. AVM_ADDR = 0, AVM_BYTE_EN = 0, AVM_WRITEDATA = 0. Reset during a fill aborts the fill immediately; any partial write is dropped and no DONE is produced.
- All outputs are registered.
- States: IDLE, CHECK, WRITE, FIN.
- IDLE: START=1 latches X0/Y0/X1/Y1/FILL_CHAR and moves to CHECK. START in any other state is ignored.
- CHECK (1 cycle): the rectangle is illegal if X0>X1, Y0>Y1, X1>=COLS or Y1>=ROWS.
  - Illegal: ERR=1 for one cycle, return to IDLE, no bus activity.
  - Legal: set BUSY=1, set col=X0 and row=Y0, load the first beat, go to WRITE.
- Beat formation from (col, row):
  - AVM_ADDR = BASE_ADDR + row*WORDS_PER_ROW + col[6:1].
  - AVM_WRITEDATA = {FILL_CHAR, FILL_CHAR}.
  - col even and col+1<=X1: BYTE_EN=4'b1111, step 2.
  - col even and col==X1: BYTE_EN=4'b0011, step 1.
  - col odd: BYTE_EN=4'b1100, step 1.
  - The even column occupies bits [15:0]; the odd column occupies bits [31:16].
- WRITE: AVM_WRITE=AVM_CS=1. A beat is accepted on a rising edge with AVM_WRITE=1 and AVM_WAITREQUEST=0.
  - While stalled, ADDR, BYTE_EN and WRITEDATA hold stable.
  - On acceptance, col advances by step. If col passes X1, col=X0 and row increments.
  - The next beat is presented on the following cycle with no idle gap, so there is one beat per cycle with no stalls.
  - Acceptance of the beat at the last cell (X1, Y1) sends the state to FIN and deasserts AVM_WRITE on the same edge.
- FIN (1 cycle): DONE=1 and BUSY=0, then return to IDLE. A new START is sampled in the IDLE cycle that follows.
- Beat count per row = ceil-pairs over [X0,X1]. Equivalently: (X0 odd ? 1 : 0) + remaining span/2 full words + (trailing even column ? 1 : 0).
- Arithmetic: row*WORDS_PER_ROW is computed at 11 bits and zero-extended to 12 bits. The maximum address is 1199 (0x4AF), so bit 11 is never set and palette registers are never written.
- The block never reads (no read port); AVM_WRITE is never asserted outside WRITE.

Test Plan:
- Single cell X0=X1=3, Y0=Y1=2, FILL_CHAR=16'h8141, no stalls -> exactly one write: ADDR=81, BE=1100, DATA=32'h8141_8141. DONE pulses two cycles after that accept; BUSY falls with DONE.
- Ragged row X0=1, X1=4, Y=0 -> three back-to-back writes: (0, 1100), (1, 1111), (2, 0011). Then DONE.
- Full screen 0..79 x 0..29 -> 1200 writes, ADDR 0..1199 in order, all BE=1111, no gaps with AVM_WAITREQUEST=0. One DONE pulse.
- AVM_WAITREQUEST held high for 3 cycles on the second beat of the ragged-row case -> ADDR, BE and DATA stay frozen for 4 cycles. Total writes still 3; no beat is duplicated or skipped.
- Illegal commands X1=80 and, separately, Y0=5/Y1=4 -> ERR pulses once each, AVM_WRITE stays 0, BUSY stays 0. START mid-fill is ignored and the write count is unchanged.
- RESET asserted asynchronously mid-fill (between clock edges) -> AVM_WRITE, BUSY and DONE go to 0 immediately. After release, a fresh legal START completes normally.
